// File: rtl/fft_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : fft_iter_core
// Purpose  : Iterative radix-2 DIT FFT: one time-shared butterfly over an
//            in-place buffer, bit-reversed load, natural-order unload.
//            Optional macro FFT_STAGE_SCALE_EN halves every butterfly output.
// Revision : 1.0
// ============================================================================
module fft_iter_core #(
  parameter int N_POINTS = 8,
  parameter int DATA_W   = 12,
  parameter int TW_W     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_real,
  output logic signed [DATA_W-1:0] m_imag,
  output logic                     m_last,
  output logic                     busy
);

  localparam int AW = $clog2(N_POINTS);
  localparam int HW = AW - 1;
  localparam int SW = (AW > 1) ? $clog2(AW) : 1;
  localparam int PW = DATA_W + TW_W + 1;
`ifdef FFT_STAGE_SCALE_EN
  localparam int SUMW = DATA_W + 1;
`else
  localparam int SUMW = DATA_W;
`endif
  localparam logic [SW-1:0] C_LAST_STAGE = SW'(AW - 1);
  localparam logic [HW-1:0] C_LAST_J     = HW'(N_POINTS / 2 - 1);
  localparam logic [AW-1:0] C_LAST_CNT   = AW'(N_POINTS - 1);
  localparam logic [AW-1:0] C_PENULT_CNT = AW'(N_POINTS - 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CALC   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   cnt_q;
  logic [SW-1:0]   stage_q;
  logic [HW-1:0]   j_q;
  logic            s_ready_q;
  logic            m_valid_q;
  logic            m_last_q;
  logic            busy_q;

  logic signed [DATA_W-1:0] mem_re_q [N_POINTS];
  logic signed [DATA_W-1:0] mem_im_q [N_POINTS];

  function automatic logic [AW-1:0] bitrev_f(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  // Q1.(TW_W-2) twiddle W^k = cos - i*sin, rounded to nearest
  function automatic logic signed [TW_W-1:0] tw_f(input int k, input bit imag);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N_POINTS);
    v   = imag ? -$sin(ang) : $cos(ang);
    return TW_W'($rtoi($floor(v * real'(1 << (TW_W - 2)) + 0.5)));
  endfunction

  logic signed [TW_W-1:0] w_tw_re [N_POINTS/2];
  logic signed [TW_W-1:0] w_tw_im [N_POINTS/2];

  for (genvar g = 0; g < N_POINTS / 2; g++) begin : g_tw_rom
    assign w_tw_re[g] = tw_f(g, 1'b0);
    assign w_tw_im[g] = tw_f(g, 1'b1);
  end

  // Butterfly addressing: a = (j/h)*2h + (j mod h), b = a + h
  logic [AW-1:0] w_jx;
  logic [AW-1:0] w_hbit;
  logic [AW-1:0] w_mask;
  logic [AW-1:0] w_a;
  logic [AW-1:0] w_b;
  logic [HW-1:0] w_k;

  assign w_jx   = {1'b0, j_q};
  assign w_hbit = AW'(1) << stage_q;
  assign w_mask = w_hbit - AW'(1);
  assign w_a    = ((w_jx & ~w_mask) << 1) | (w_jx & w_mask);
  assign w_b    = w_a | w_hbit;
  assign w_k    = HW'((w_jx & w_mask) << (C_LAST_STAGE - stage_q));

  logic signed [PW-1:0]   w_br, w_bi, w_wr, w_wi, w_pr, w_pi;
  logic signed [SUMW-1:0] w_tr, w_ti, w_ar, w_ai;
  logic signed [SUMW-1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;
  logic signed [DATA_W-1:0] bf_a_re_d, bf_a_im_d, bf_b_re_d, bf_b_im_d;

  assign w_br = PW'(mem_re_q[w_b]);
  assign w_bi = PW'(mem_im_q[w_b]);
  assign w_wr = PW'(w_tw_re[w_k]);
  assign w_wi = PW'(w_tw_im[w_k]);
  assign w_pr = w_br * w_wr - w_bi * w_wi;
  assign w_pi = w_br * w_wi + w_bi * w_wr;
  assign w_tr = SUMW'(w_pr >>> (TW_W - 2));
  assign w_ti = SUMW'(w_pi >>> (TW_W - 2));
  assign w_ar = SUMW'(mem_re_q[w_a]);
  assign w_ai = SUMW'(mem_im_q[w_a]);

  assign w_sum_re = w_ar + w_tr;
  assign w_sum_im = w_ai + w_ti;
  assign w_dif_re = w_ar - w_tr;
  assign w_dif_im = w_ai - w_ti;

`ifdef FFT_STAGE_SCALE_EN
  // One guard bit kept so the halving is exact before truncation
  assign bf_a_re_d = w_sum_re[SUMW-1:1];
  assign bf_a_im_d = w_sum_im[SUMW-1:1];
  assign bf_b_re_d = w_dif_re[SUMW-1:1];
  assign bf_b_im_d = w_dif_im[SUMW-1:1];
`else
  assign bf_a_re_d = w_sum_re;
  assign bf_a_im_d = w_sum_im;
  assign bf_b_re_d = w_dif_re;
  assign bf_b_im_d = w_dif_im;
`endif

  logic [AW-1:0] w_ld_addr;
  assign w_ld_addr = bitrev_f(cnt_q);

  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && s_valid) begin
      mem_re_q[w_ld_addr] <= s_data;
      mem_im_q[w_ld_addr] <= '0;
    end else if (state_q == ST_CALC) begin
      mem_re_q[w_a] <= bf_a_re_d;
      mem_im_q[w_a] <= bf_a_im_d;
      mem_re_q[w_b] <= bf_b_re_d;
      mem_im_q[w_b] <= bf_b_im_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      stage_q   <= '0;
      j_q       <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q   <= ST_LOAD;
          cnt_q     <= '0;
          s_ready_q <= 1'b1;
        end
        ST_LOAD: begin
          if (s_valid) begin
            if (cnt_q == C_LAST_CNT) begin
              state_q   <= ST_CALC;
              cnt_q     <= '0;
              stage_q   <= '0;
              j_q       <= '0;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + AW'(1);
            end
          end
        end
        ST_CALC: begin
          if (j_q == C_LAST_J) begin
            j_q <= '0;
            if (stage_q == C_LAST_STAGE) begin
              state_q   <= ST_UNLOAD;
              cnt_q     <= '0;
              stage_q   <= '0;
              m_valid_q <= 1'b1;
              m_last_q  <= 1'b0;
            end else begin
              stage_q <= stage_q + SW'(1);
            end
          end else begin
            j_q <= j_q + HW'(1);
          end
        end
        ST_UNLOAD: begin
          if (m_ready) begin
            if (cnt_q == C_LAST_CNT) begin
              state_q   <= ST_LOAD;
              cnt_q     <= '0;
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              busy_q    <= 1'b0;
              s_ready_q <= 1'b1;
            end else begin
              cnt_q    <= cnt_q + AW'(1);
              m_last_q <= (cnt_q == C_PENULT_CNT);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign m_real  = (state_q == ST_UNLOAD) ? mem_re_q[cnt_q] : '0;
  assign m_imag  = (state_q == ST_UNLOAD) ? mem_im_q[cnt_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fft_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_iter_core
// Purpose  : Directed self-checking bench for fft_iter_core (N=8, 12-bit).
// Revision : 1.0
// ============================================================================
module tb_fft_iter_core;

  logic clk = 1'b0;
  logic rst;
  logic s_valid;
  logic s_ready;
  logic signed [11:0] s_data;
  logic m_valid;
  logic m_ready;
  logic signed [11:0] m_real;
  logic signed [11:0] m_imag;
  logic m_last;
  logic busy;

  int total = 0;
  int bad   = 0;

  logic signed [11:0] in_v   [8];
  logic signed [11:0] exp_re [8];
  logic signed [11:0] exp_im [8];
  logic signed [11:0] got_re [8];
  logic signed [11:0] got_im [8];
  logic               got_last [8];

  fft_iter_core #(
    .N_POINTS (8),
    .DATA_W   (12),
    .TW_W     (12)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_real  (m_real),
    .m_imag  (m_imag),
    .m_last  (m_last),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1, "timeout");
  end

  task automatic load_frame();
    int guard = 0;
    while (s_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_wait s_ready=%0b want 1", s_ready);
    end
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = in_v[i];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic unload_frame();
    int n = 0;
    int guard = 0;
    m_ready = 1'b1;
    while (n < 8 && guard < 100) begin
      if (m_valid === 1'b1) begin
        got_re[n]   = m_real;
        got_im[n]   = m_imag;
        got_last[n] = m_last;
        n++;
      end
      @(posedge clk); #1;
      guard++;
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL unload_count got %0d bins want 8", n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    total++;
    if ({s_ready, m_valid, m_last, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got %b want 0000", {s_ready, m_valid, m_last, busy});
    end
    total++;
    if (m_real !== 12'sd0 || m_imag !== 12'sd0) begin
      bad++;
      $display("FAIL reset_data got %0d/%0d want 0/0", m_real, m_imag);
    end
    rst = 1'b0;
    #1;
    total++;
    if (s_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle s_ready=%0b want 0", s_ready);
    end
    @(posedge clk); #1;
    total++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_load s_ready=%0b busy=%0b want 1 0", s_ready, busy);
    end
  endtask

  task automatic test_impulse();
    in_v = '{12'sd100, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0};
    for (int k = 0; k < 8; k++) begin
`ifdef FFT_STAGE_SCALE_EN
      exp_re[k] = 12'sd12;
`else
      exp_re[k] = 12'sd100;
`endif
      exp_im[k] = 12'sd0;
    end
    load_frame();
    unload_frame();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (got_re[k] !== exp_re[k] || got_im[k] !== exp_im[k]) begin
        bad++;
        $display("FAIL impulse bin%0d got %0d,%0d want %0d,%0d", k, got_re[k], got_im[k], exp_re[k], exp_im[k]);
      end
    end
  endtask

  task automatic test_dc();
    for (int k = 0; k < 8; k++) begin
      in_v[k]   = 12'sd64;
      exp_re[k] = 12'sd0;
      exp_im[k] = 12'sd0;
    end
`ifdef FFT_STAGE_SCALE_EN
    exp_re[0] = 12'sd64;
`else
    exp_re[0] = 12'sd512;
`endif
    load_frame();
    unload_frame();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (got_re[k] !== exp_re[k] || got_im[k] !== exp_im[k]) begin
        bad++;
        $display("FAIL dc bin%0d got %0d,%0d want %0d,%0d", k, got_re[k], got_im[k], exp_re[k], exp_im[k]);
      end
    end
  endtask

  task automatic test_alternating();
    for (int k = 0; k < 8; k++) begin
      in_v[k]   = (k % 2 == 0) ? 12'sd100 : -12'sd100;
      exp_re[k] = 12'sd0;
      exp_im[k] = 12'sd0;
    end
`ifdef FFT_STAGE_SCALE_EN
    exp_re[4] = 12'sd100;
`else
    exp_re[4] = 12'sd800;
`endif
    load_frame();
    unload_frame();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (got_re[k] !== exp_re[k] || got_im[k] !== exp_im[k]) begin
        bad++;
        $display("FAIL alt bin%0d got %0d,%0d want %0d,%0d", k, got_re[k], got_im[k], exp_re[k], exp_im[k]);
      end
      total++;
      if (got_last[k] !== (k == 7)) begin
        bad++;
        $display("FAIL alt_last bin%0d got %0b want %0b", k, got_last[k], (k == 7));
      end
    end
  endtask

  // Impulse at x[1]: bins are 100*W^k, exercising every twiddle and floor rounding
  task automatic set_shifted_impulse();
    in_v = '{12'sd0, 12'sd100, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0};
`ifdef FFT_STAGE_SCALE_EN
    exp_re = '{12'sd12, 12'sd8, 12'sd0, -12'sd9, -12'sd13, -12'sd9, 12'sd0, 12'sd9};
    exp_im = '{12'sd0, -12'sd9, -12'sd13, -12'sd9, 12'sd0, 12'sd9, 12'sd12, 12'sd9};
`else
    exp_re = '{12'sd100, 12'sd70, 12'sd0, -12'sd71, -12'sd100, -12'sd70, 12'sd0, 12'sd71};
    exp_im = '{12'sd0, -12'sd71, -12'sd100, -12'sd71, 12'sd0, 12'sd71, 12'sd100, 12'sd71};
`endif
  endtask

  task automatic test_twiddle();
    set_shifted_impulse();
    load_frame();
    unload_frame();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (got_re[k] !== exp_re[k] || got_im[k] !== exp_im[k]) begin
        bad++;
        $display("FAIL twiddle bin%0d got %0d,%0d want %0d,%0d", k, got_re[k], got_im[k], exp_re[k], exp_im[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int guard = 0;
    bit stalled = 1'b0;
    set_shifted_impulse();
    m_ready = 1'b0;
    load_frame();
    total++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL calc_flags s_ready=%0b busy=%0b want 0 1", s_ready, busy);
    end
    s_valid = 1'b1;
    s_data  = 12'sd999;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (s_ready !== 1'b0) begin
        bad++;
        $display("FAIL calc_s_ready got %0b want 0", s_ready);
      end
    end
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    while (n < 8 && guard < 100) begin
      if (m_valid === 1'b1) begin
        if (n == 2 && !stalled) begin
          m_ready = 1'b0;
          repeat (3) begin
            @(posedge clk); #1;
            total++;
            if (m_valid !== 1'b1 || m_real !== exp_re[2] || m_imag !== exp_im[2]) begin
              bad++;
              $display("FAIL stall_hold got v=%0b %0d,%0d want v=1 %0d,%0d", m_valid, m_real, m_imag, exp_re[2], exp_im[2]);
            end
          end
          m_ready = 1'b1;
          stalled = 1'b1;
        end
        got_re[n] = m_real;
        got_im[n] = m_imag;
        n++;
      end
      @(posedge clk); #1;
      guard++;
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL bp_count got %0d bins want 8", n);
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (got_re[k] !== exp_re[k] || got_im[k] !== exp_im[k]) begin
        bad++;
        $display("FAIL bp bin%0d got %0d,%0d want %0d,%0d", k, got_re[k], got_im[k], exp_re[k], exp_im[k]);
      end
    end
  endtask

  task automatic test_latency();
    int cyc = 0;
    in_v = '{12'sd100, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0};
    m_ready = 1'b1;
    load_frame();
    while (m_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (cyc != 12) begin
      bad++;
      $display("FAIL latency got %0d edges after last beat want 12", cyc);
    end
    unload_frame();
    total++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL return_load s_ready=%0b m_valid=%0b busy=%0b want 1 0 0", s_ready, m_valid, busy);
    end
    total++;
`ifdef FFT_STAGE_SCALE_EN
    if (got_re[7] !== 12'sd12) begin
`else
    if (got_re[7] !== 12'sd100) begin
`endif
      bad++;
      $display("FAIL latency_bin7 got %0d", got_re[7]);
    end
  endtask

  task automatic test_reset_mid_calc();
    in_v = '{12'sd100, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0};
    load_frame();
    repeat (4) begin @(posedge clk); #1; end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_calc busy=%0b want 1", busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({s_ready, m_valid, m_last, busy} !== 4'b0000 || m_real !== 12'sd0 || m_imag !== 12'sd0) begin
      bad++;
      $display("FAIL abort_outputs flags=%b data=%0d,%0d want 0000 0,0", {s_ready, m_valid, m_last, busy}, m_real, m_imag);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if (s_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle s_ready=%0b want 0", s_ready);
    end
    @(posedge clk); #1;
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_load s_ready=%0b want 1", s_ready);
    end
    load_frame();
    unload_frame();
    for (int k = 0; k < 8; k++) begin
      total++;
`ifdef FFT_STAGE_SCALE_EN
      if (got_re[k] !== 12'sd12 || got_im[k] !== 12'sd0) begin
`else
      if (got_re[k] !== 12'sd100 || got_im[k] !== 12'sd0) begin
`endif
        bad++;
        $display("FAIL post_abort bin%0d got %0d,%0d", k, got_re[k], got_im[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_alternating();
    test_twiddle();
    test_backpressure();
    test_latency();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
